// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU sharing arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int NREQ_MAX = 8;

endpackage

// File: rtl/cpu_types_pkg.sv
// ALU opcode encodings shared by the CPU datapath and every ALU client.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int  NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU among NREQ requesters: round-robin grant,
// operand latch, one execute cycle, then a held response until the owner takes it.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int  NREQ = 2,
  parameter int  DW   = 32,
  parameter int  OPW  = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*OPW-1:0] req_op,
  input  logic [NREQ*DW-1:0]  req_a,
  input  logic [NREQ*DW-1:0]  req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [DW-1:0]     rsp_result,
  output logic [2:0]        rsp_flags,
  output logic [DW-1:0]     alu_pa,
  output logic [DW-1:0]     alu_pb,
  output logic [OPW-1:0]    alu_op,
  input  logic [DW-1:0]     alu_presult,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  input  logic              alu_neg,
  output logic [15:0]       ops_done
);

  arb_state_t      state, state_next;
  logic [IW-1:0]   rr_ptr, owner, grant_idx;
  logic [NREQ-1:0] grant, owner_oh;
  logic            grant_any;
  logic [OPW-1:0]  op_q;
  logic [DW-1:0]   a_q, b_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign alu_pa = a_q;
  assign alu_pb = b_q;
  assign alu_op = op_q;

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  // Handshakes are gated by nRST so nothing is offered while reset is held.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    case (state)
      IDLE: begin
        if (nRST) req_ready = grant;
        if (grant_any) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (nRST) rsp_valid = owner_oh;
        if (rsp_ready[owner]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr     <= '0;
      owner      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      ops_done   <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        owner <= grant_idx;
        op_q  <= req_op[grant_idx*OPW +: OPW];
        a_q   <= req_a[grant_idx*DW +: DW];
        b_q   <= req_b[grant_idx*DW +: DW];
      end
      if (state == EXEC) begin
        rsp_result <= alu_presult;
        rsp_flags  <= {alu_neg, alu_ovf, alu_zero};
      end
      // Advancing past the owner makes a re-requesting owner lose to others.
      if (state == RESP && rsp_ready[owner]) begin
        ops_done <= ops_done + 16'd1;
        rr_ptr   <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU model.
module tb_alu_share_arbiter;
  import cpu_types_pkg::*;

  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int OPW  = 4;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*OPW-1:0] req_op;
  logic [NREQ*DW-1:0]  req_a, req_b;
  logic [DW-1:0]   rsp_result, alu_pa, alu_pb, alu_presult;
  logic [2:0]      rsp_flags;
  logic [OPW-1:0]  alu_op;
  logic            alu_zero, alu_ovf, alu_neg;
  logic [15:0]     ops_done;

  int assert_count = 0;
  int fail_count   = 0;
  int cnt0, cnt1;
  logic [NREQ-1:0] exp_g;

  alu_share_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .alu_pa      (alu_pa),
    .alu_pb      (alu_pb),
    .alu_op      (alu_op),
    .alu_presult (alu_presult),
    .alu_zero    (alu_zero),
    .alu_ovf     (alu_ovf),
    .alu_neg     (alu_neg),
    .ops_done    (ops_done)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the shared combinational ALU.
  always_comb begin
    alu_presult = '0;
    alu_ovf     = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_presult = alu_pa + alu_pb;
        alu_ovf = (alu_pa[31] == alu_pb[31]) && (alu_presult[31] != alu_pa[31]);
      end
      ALU_SUB: begin
        alu_presult = alu_pa - alu_pb;
        alu_ovf = (alu_pa[31] != alu_pb[31]) && (alu_presult[31] != alu_pa[31]);
      end
      ALU_AND: alu_presult = alu_pa & alu_pb;
      ALU_OR:  alu_presult = alu_pa | alu_pb;
      default: alu_presult = alu_pa ^ alu_pb;
    endcase
    alu_zero = (alu_presult == '0);
    alu_neg  = alu_presult[31];
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[idx*OPW +: OPW] = op;
    req_a[idx*DW +: DW]    = a;
    req_b[idx*DW +: DW]    = b;
  endtask

  // Full transaction from a single requester; leaves the FSM back in IDLE.
  task automatic do_op(input string tag, input int idx, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic [2:0] exp_flags);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    set_req(idx, op, a, b);
    req_valid = oh;
    #1;
    check({tag, "_req_ready"}, 32'(req_ready), 32'(oh));
    tick();
    req_valid = '0;
    check({tag, "_exec_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_alu_pa"}, alu_pa, a);
    tick();
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(oh));
    check({tag, "_result"}, rsp_result, exp_res);
    check({tag, "_flags"}, 32'(rsp_flags), 32'(exp_flags));
    rsp_ready = oh;
    tick();
    rsp_ready = '0;
    check({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    nRST      = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_ops_done", 32'(ops_done), 32'd0);
    check("rst_alu_pa", alu_pa, 32'd0);
    nRST = 1'b1;
    tick();

    do_op("add", 0, ALU_ADD, 32'd5, 32'd7, 32'd12, 3'b000);
    check("add_ops_done", 32'(ops_done), 32'd1);

    do_op("sub_ovf", 1, ALU_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 3'b010);
    do_op("sub_zero", 1, ALU_SUB, 32'd3, 32'd3, 32'd0, 3'b001);
    check("flags_ops_done", 32'(ops_done), 32'd3);

    // Both requesters stay valid; grants must alternate starting with 0.
    set_req(0, ALU_ADD, 32'd10, 32'd20);
    set_req(1, ALU_SUB, 32'd50, 32'd8);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    cnt0 = 0;
    cnt1 = 0;
    #1;
    for (int i = 0; i < 8; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      check("cont_grant", 32'(req_ready), 32'(exp_g));
      tick();
      tick();
      check("cont_rsp_valid", 32'(rsp_valid), 32'(exp_g));
      check("cont_result", rsp_result, (i % 2 == 0) ? 32'd30 : 32'd42);
      if (rsp_valid[0]) cnt0++;
      if (rsp_valid[1]) cnt1++;
      tick();
    end
    req_valid = '0;
    rsp_ready = '0;
    check("cont_cnt0", 32'(cnt0), 32'd4);
    check("cont_cnt1", 32'(cnt1), 32'd4);
    check("cont_ops_done", 32'(ops_done), 32'd11);

    // Owner 0 withholds rsp_ready while requester 1 pushes on both handshakes.
    set_req(0, ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    req_valid = 2'b01;
    #1;
    check("bp_req_ready", 32'(req_ready), 32'd1);
    tick();
    tick();
    req_valid = 2'b11;
    rsp_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_result", rsp_result, 32'h8000_0000);
      check("bp_flags", 32'(rsp_flags), 32'b110);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_ops_done", 32'(ops_done), 32'd11);
      tick();
    end
    req_valid = '0;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    check("bp_accept_ops_done", 32'(ops_done), 32'd12);
    check("bp_accept_rsp_valid", 32'(rsp_valid), 32'd0);

    // Jump the completion counter to its top value instead of running 65535 ops.
    force dut.ops_done = 16'hFFFF;
    #1;
    release dut.ops_done;
    do_op("wrap", 0, ALU_OR, 32'h0F0, 32'h00F, 32'h0FF, 3'b000);
    check("wrap_ops_done", 32'(ops_done), 32'd0);
    do_op("post_wrap", 1, ALU_AND, 32'hFF00_FF00, 32'hF0F0_F0F0, 32'hF000_F000, 3'b100);
    check("post_wrap_ops_done", 32'(ops_done), 32'd1);

    // Reset lands while a response is waiting.
    set_req(1, ALU_ADD, 32'd9, 32'd1);
    req_valid = 2'b10;
    tick();
    tick();
    check("mid_rsp_valid", 32'(rsp_valid), 32'd2);
    req_valid = 2'b11;
    nRST = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_ops_done", 32'(ops_done), 32'd0);
    check("mid_rst_alu_pa", alu_pa, 32'd0);
    tick();
    req_valid = '0;
    nRST = 1'b1;
    tick();
    check("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
